// File: rtl/lvds_deserializer.sv
// lvds_deserializer: serial shift-in, training-pattern word alignment and framed word output
module lvds_deserializer #(
  parameter int PARALLEL_WIDTH = 8,
  parameter int SERIAL_RATIO = 8,
  parameter logic [PARALLEL_WIDTH-1:0] SYNC_PATTERN = 8'hA5,
  parameter int LOCK_COUNT = 4
) (
  input  logic                      clk_serial,
  input  logic                      reset,
  input  logic                      serial_in,
  input  logic                      realign,
  output logic [PARALLEL_WIDTH-1:0] deserialized_word,
  output logic                      rx_frame_pulse,
  output logic                      locked,
  output logic                      align_error
);
  localparam int CW = $clog2(SERIAL_RATIO);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int PW = $clog2(SERIAL_RATIO / 2 + 1);
  localparam logic [CW-1:0] LAST = CW'(SERIAL_RATIO - 1);
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
  state_t state;
  logic [PARALLEL_WIDTH-1:0] sr;
  logic [CW-1:0] bit_cnt;
  logic [MW-1:0] match_cnt;
  logic [PW-1:0] pulse_cnt;
  logic match, boundary;
  assign match = sr == SYNC_PATTERN;
  assign boundary = bit_cnt == '0;
  assign rx_frame_pulse = pulse_cnt != '0;
  always_ff @(posedge clk_serial) begin
    if (reset) begin
      state <= HUNT;
      sr <= '0;
      bit_cnt <= '0;
      match_cnt <= '0;
      pulse_cnt <= '0;
      deserialized_word <= '0;
      locked <= 1'b0;
      align_error <= 1'b0;
    end else begin
      sr <= {sr[PARALLEL_WIDTH-2:0], serial_in};
      bit_cnt <= bit_cnt == LAST ? '0 : bit_cnt + 1'b1;
      align_error <= 1'b0;
      if (pulse_cnt != '0) pulse_cnt <= pulse_cnt - 1'b1;
      if (realign) begin
        state <= HUNT;
        match_cnt <= '0;
        pulse_cnt <= '0;
        locked <= 1'b0;
      end else begin
        case (state)
          HUNT: if (match) begin
            bit_cnt <= CW'(1);
            match_cnt <= MW'(1);
            state <= VERIFY;
          end
          VERIFY: if (boundary) begin
            if (match) begin
              match_cnt <= match_cnt + 1'b1;
              if (match_cnt + 1'b1 == MW'(LOCK_COUNT)) begin
                state <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              align_error <= 1'b1;
              match_cnt <= '0;
              state <= HUNT;
            end
          end
          LOCKED: if (boundary) begin
            deserialized_word <= sr;
            pulse_cnt <= PW'(SERIAL_RATIO / 2);
          end
          default: state <= HUNT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_lvds_deserializer.sv
// tb_lvds_deserializer: scoreboard bench for alignment, lock, framing, realign and reset
module tb_lvds_deserializer;
  logic clk_serial = 1'b0;
  logic reset = 1'b1, serial_in = 1'b0, realign = 1'b0;
  logic [7:0] deserialized_word;
  logic rx_frame_pulse, locked, align_error;
  int checks = 0, passes = 0;
  int cyc = 0;
  logic [7:0] exp_w[$], obs_w[$];
  int exp_t[$], obs_t[$], obs_len[$];
  logic prev_pulse = 1'b0, prev_lock = 1'b0, prev_err = 1'b0, prev_rst = 1'b0;
  logic [7:0] prev_word = 8'h00;
  int width = 0, lock_rises = 0, lock_rise_cyc = -1, err_pulses = 0, err_cyc = -1, err_long = 0, word_glitch = 0;

  lvds_deserializer dut (
    .clk_serial(clk_serial), .reset(reset), .serial_in(serial_in), .realign(realign),
    .deserialized_word(deserialized_word), .rx_frame_pulse(rx_frame_pulse),
    .locked(locked), .align_error(align_error)
  );

  always #5 clk_serial = ~clk_serial;
  always @(posedge clk_serial) cyc <= cyc + 1;

  always @(negedge clk_serial) begin
    if (rx_frame_pulse && !prev_pulse) begin
      obs_w.push_back(deserialized_word);
      obs_t.push_back(cyc);
    end
    if (rx_frame_pulse) width++;
    else if (prev_pulse) begin
      obs_len.push_back(width);
      width = 0;
    end
    if (locked && !prev_lock) begin
      lock_rises++;
      lock_rise_cyc = cyc;
    end
    if (align_error && !prev_err) begin
      err_pulses++;
      err_cyc = cyc;
    end
    if (align_error && prev_err) err_long++;
    if (deserialized_word !== prev_word && !(rx_frame_pulse && !prev_pulse) && !prev_rst) word_glitch++;
    prev_pulse = rx_frame_pulse;
    prev_lock = locked;
    prev_err = align_error;
    prev_rst = reset;
    prev_word = deserialized_word;
  end

  task automatic drive_bit(input logic b);
    serial_in = b;
    @(posedge clk_serial);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input bit push);
    for (int i = 7; i >= 0; i--) drive_bit(w[i]);
    if (push) begin
      exp_w.push_back(w);
      exp_t.push_back(cyc + 1);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    realign = 1'b0;
    drive_bit(1'b0);
    drive_bit(1'b0);
    reset = 1'b0;
  endtask

  task automatic train();
    for (int i = 0; i < 12; i++) drive_bit(1'b0);
    for (int i = 0; i < 4; i++) send_word(8'hA5, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (deserialized_word !== 8'h00) $display("FAIL reset_word: got %h want 00", deserialized_word); else passes++;
    checks++; if (rx_frame_pulse !== 1'b0) $display("FAIL reset_pulse: got %b want 0", rx_frame_pulse); else passes++;
    checks++; if (locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", locked); else passes++;
    checks++; if (align_error !== 1'b0) $display("FAIL reset_err: got %b want 0", align_error); else passes++;
  endtask

  task automatic test_zero_stream();
    int lr, no;
    lr = lock_rises;
    no = obs_w.size();
    for (int i = 0; i < 40; i++) drive_bit(1'b0);
    checks++; if (lock_rises !== lr) $display("FAIL zero_lock: got %0d lock rises want %0d", lock_rises, lr); else passes++;
    checks++; if (obs_w.size() !== no) $display("FAIL zero_pulse: got %0d frames want %0d", obs_w.size(), no); else passes++;
    checks++; if (deserialized_word !== 8'h00) $display("FAIL zero_word: got %h want 00", deserialized_word); else passes++;
    checks++; if (rx_frame_pulse !== 1'b0) $display("FAIL zero_pulse_now: got %b want 0", rx_frame_pulse); else passes++;
  endtask

  task automatic test_lock();
    int lr, e0, t;
    do_reset();
    lr = lock_rises;
    e0 = err_pulses;
    train();
    t = cyc + 1;
    checks++; if (locked !== 1'b0) $display("FAIL lock_early: got %b want 0", locked); else passes++;
    send_word(8'hA5, 1'b1);
    checks++; if (lock_rises !== lr + 1) $display("FAIL lock_rise: got %0d rises want %0d", lock_rises, lr + 1); else passes++;
    checks++; if (lock_rise_cyc !== t) $display("FAIL lock_time: got cycle %0d want %0d", lock_rise_cyc, t); else passes++;
    checks++; if (err_pulses !== e0) $display("FAIL lock_err: got %0d errors want %0d", err_pulses, e0); else passes++;
  endtask

  task automatic test_data();
    logic [7:0] ow, ew;
    int ot, et, ln;
    send_word(8'h3C, 1'b1);
    send_word(8'hFF, 1'b1);
    send_word(8'h00, 1'b1);
    send_word(8'h5A, 1'b1);
    while (obs_w.size() > 0) begin
      ow = obs_w.pop_front();
      ot = obs_t.pop_front();
      checks++;
      if (exp_w.size() == 0) $display("FAIL data_extra: got word %h with none expected", ow);
      else begin
        ew = exp_w.pop_front();
        et = exp_t.pop_front();
        if (ow !== ew) $display("FAIL data_word: got %h want %h", ow, ew); else passes++;
        checks++; if (ot !== et) $display("FAIL data_time: got cycle %0d want %0d", ot, et); else passes++;
      end
    end
    while (obs_len.size() > 0) begin
      ln = obs_len.pop_front();
      checks++; if (ln !== 4) $display("FAIL data_width: got %0d want 4", ln); else passes++;
    end
    checks++; if (exp_w.size() !== 1) $display("FAIL data_pending: got %0d want 1", exp_w.size()); else passes++;
    checks++; if (word_glitch !== 0) $display("FAIL data_hold: got %0d glitches want 0", word_glitch); else passes++;
  endtask

  task automatic test_realign();
    logic [7:0] ow, ew;
    int ot, et, ln, lr, t;
    send_word(8'h66, 1'b1);
    send_word(8'h77, 1'b0);
    realign = 1'b1;
    drive_bit(1'b0);
    realign = 1'b0;
    checks++; if (locked !== 1'b0) $display("FAIL realign_locked: got %b want 0", locked); else passes++;
    checks++; if (rx_frame_pulse !== 1'b0) $display("FAIL realign_pulse: got %b want 0", rx_frame_pulse); else passes++;
    checks++; if (deserialized_word !== 8'h66) $display("FAIL realign_word: got %h want 66", deserialized_word); else passes++;
    lr = lock_rises;
    train();
    t = cyc + 1;
    send_word(8'hE7, 1'b1);
    checks++; if (lock_rises !== lr + 1 || lock_rise_cyc !== t) $display("FAIL relock: got %0d rises at %0d want %0d at %0d", lock_rises, lock_rise_cyc, lr + 1, t); else passes++;
    for (int i = 0; i < 6; i++) drive_bit(1'b0);
    while (obs_w.size() > 0) begin
      ow = obs_w.pop_front();
      ot = obs_t.pop_front();
      checks++;
      if (exp_w.size() == 0) $display("FAIL realign_extra: got word %h with none expected", ow);
      else begin
        ew = exp_w.pop_front();
        et = exp_t.pop_front();
        if (ow !== ew) $display("FAIL realign_word_sb: got %h want %h", ow, ew); else passes++;
        checks++; if (ot !== et) $display("FAIL realign_time: got cycle %0d want %0d", ot, et); else passes++;
      end
    end
    while (obs_len.size() > 0) begin
      ln = obs_len.pop_front();
      checks++; if (ln !== 4) $display("FAIL realign_width: got %0d want 4", ln); else passes++;
    end
    checks++; if (exp_w.size() !== 0) $display("FAIL realign_missing: got %0d pending want 0", exp_w.size()); else passes++;
  endtask

  task automatic test_verify_fail();
    int e0, lr, t;
    do_reset();
    e0 = err_pulses;
    lr = lock_rises;
    for (int i = 0; i < 12; i++) drive_bit(1'b0);
    send_word(8'hA5, 1'b0);
    send_word(8'hA5, 1'b0);
    send_word(8'h12, 1'b0);
    t = cyc + 1;
    for (int i = 0; i < 8; i++) drive_bit(1'b0);
    checks++; if (err_pulses !== e0 + 1) $display("FAIL verify_err: got %0d errors want %0d", err_pulses, e0 + 1); else passes++;
    checks++; if (err_cyc !== t) $display("FAIL verify_err_time: got cycle %0d want %0d", err_cyc, t); else passes++;
    checks++; if (err_long !== 0) $display("FAIL verify_err_width: got %0d long cycles want 0", err_long); else passes++;
    checks++; if (lock_rises !== lr || locked !== 1'b0) $display("FAIL verify_locked: got %0d rises locked=%b want %0d and 0", lock_rises, locked, lr); else passes++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] ow, ew;
    int ot, et, ln, lr, t;
    do_reset();
    train();
    send_word(8'hC3, 1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    checks++; if (rx_frame_pulse !== 1'b1) $display("FAIL mid_pulse: got %b want 1", rx_frame_pulse); else passes++;
    reset = 1'b1;
    drive_bit(1'b0);
    reset = 1'b0;
    checks++; if (deserialized_word !== 8'h00) $display("FAIL mid_word: got %h want 00", deserialized_word); else passes++;
    checks++; if (rx_frame_pulse !== 1'b0) $display("FAIL mid_pulse_clr: got %b want 0", rx_frame_pulse); else passes++;
    checks++; if (locked !== 1'b0 || align_error !== 1'b0) $display("FAIL mid_flags: got locked=%b err=%b want 0 0", locked, align_error); else passes++;
    lr = lock_rises;
    train();
    t = cyc + 1;
    send_word(8'h81, 1'b1);
    checks++; if (lock_rises !== lr + 1 || lock_rise_cyc !== t) $display("FAIL mid_relock: got %0d rises at %0d want %0d at %0d", lock_rises, lock_rise_cyc, lr + 1, t); else passes++;
    for (int i = 0; i < 6; i++) drive_bit(1'b0);
    while (obs_w.size() > 0) begin
      ow = obs_w.pop_front();
      ot = obs_t.pop_front();
      checks++;
      if (exp_w.size() == 0) $display("FAIL mid_extra: got word %h with none expected", ow);
      else begin
        ew = exp_w.pop_front();
        et = exp_t.pop_front();
        if (ow !== ew) $display("FAIL mid_word_sb: got %h want %h", ow, ew); else passes++;
        checks++; if (ot !== et) $display("FAIL mid_time: got cycle %0d want %0d", ot, et); else passes++;
      end
    end
    checks++; if (obs_len.size() !== 2) $display("FAIL mid_width_count: got %0d want 2", obs_len.size()); else passes++;
    if (obs_len.size() == 2) begin
      ln = obs_len.pop_front();
      checks++; if (ln !== 2) $display("FAIL mid_trunc_width: got %0d want 2", ln); else passes++;
      ln = obs_len.pop_front();
      checks++; if (ln !== 4) $display("FAIL mid_width: got %0d want 4", ln); else passes++;
    end
    checks++; if (exp_w.size() !== 0) $display("FAIL mid_missing: got %0d pending want 0", exp_w.size()); else passes++;
    checks++; if (word_glitch !== 0) $display("FAIL hold: got %0d glitches want 0", word_glitch); else passes++;
  endtask

  initial begin
    test_reset();
    test_zero_stream();
    test_lock();
    test_data();
    test_realign();
    test_verify_fail();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
